// File: rtl/mem_pkg.sv
// Shared types and sizing for the memory line controller.
package mem_pkg;

  localparam int ADDR_W_DEFAULT = 64;
  localparam int LINE_W_DEFAULT = 512;
  localparam int BUS_W_DEFAULT  = 64;
  localparam int LINE_OFFSET_W  = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WDATA = 3'd2,
    ST_RDATA = 3'd3,
    ST_DONE  = 3'd4
  } mem_state_t;

endpackage

// File: rtl/mem_beat_buffer.sv
// Line-wide holding register: whole-line load, per-beat fill from the bus, per-beat drain mux.
module mem_beat_buffer #(
  parameter int LINE_W = 512,
  parameter int BUS_W  = 64,
  parameter int IDX_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [LINE_W-1:0] load_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [BUS_W-1:0]  wr_beat,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [BUS_W-1:0]  rd_beat,
  output logic [LINE_W-1:0] fill_line
);

  logic [LINE_W-1:0] line_r;

  // Current line with the incoming beat merged, so the final beat is visible in the same cycle.
  always_comb begin
    fill_line = line_r;
    if (wr_en) begin
      fill_line[int'(wr_idx) * BUS_W +: BUS_W] = wr_beat;
    end else begin
      fill_line = line_r;
    end
  end

  // Line storage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      line_r <= '0;
    end else if (load) begin
      line_r <= load_line;
    end else if (wr_en) begin
      line_r <= fill_line;
    end else begin
      line_r <= line_r;
    end
  end

  assign rd_beat = line_r[int'(rd_idx) * BUS_W +: BUS_W];

endmodule

// File: rtl/mem_line_controller.sv
// Runs one cache-line request as an 8-beat bus burst and forwards bus snoops as invalidate pulses.
module mem_line_controller
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LINE_W = LINE_W_DEFAULT,
  parameter int BUS_W  = BUS_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_address,
  input  logic              mem_wr_en,
  input  logic [LINE_W-1:0] mem_data_in,
  output logic [LINE_W-1:0] data_from_mem,
  output logic              mem_data_valid,
  output logic              invalidate_cache,
  output logic [ADDR_W-1:0] invalidate_cache_addr,
  output logic              bus_req_valid,
  input  logic              bus_req_ready,
  output logic [ADDR_W-1:0] bus_req_addr,
  output logic              bus_req_write,
  output logic [BUS_W-1:0]  bus_wdata,
  output logic              bus_wdata_valid,
  input  logic              bus_wdata_ready,
  input  logic [BUS_W-1:0]  bus_rdata,
  input  logic              bus_rdata_valid,
  input  logic              bus_snoop_valid,
  input  logic [ADDR_W-1:0] bus_snoop_addr
);

  localparam int BEATS = LINE_W / BUS_W;
  localparam int IDX_W = $clog2(BEATS);
  localparam logic [IDX_W-1:0] LAST_BEAT = IDX_W'(BEATS - 1);

  mem_state_t        state_r;
  logic [IDX_W-1:0]  beat_cnt_r;
  logic              buf_load_s;
  logic              buf_wr_s;
  logic [IDX_W-1:0]  rd_idx_s;
  logic [BUS_W-1:0]  rd_beat_s;
  logic [LINE_W-1:0] fill_line_s;
  logic              unused_offset_bits;

  assign unused_offset_bits = ^{mem_address[LINE_OFFSET_W-1:0], bus_snoop_addr[LINE_OFFSET_W-1:0]};

  // Buffer controls; the drain index looks one beat ahead so bus_wdata can be registered.
  always_comb begin
    buf_load_s = 1'b0;
    buf_wr_s   = 1'b0;
    rd_idx_s   = '0;
    if (state_r == ST_IDLE) begin
      buf_load_s = mem_req;
    end else if (state_r == ST_RDATA) begin
      buf_wr_s = bus_rdata_valid;
    end else if (state_r == ST_WDATA) begin
      rd_idx_s = beat_cnt_r + IDX_W'(1'b1);
    end else begin
      rd_idx_s = '0;
    end
  end

  mem_beat_buffer #(
    .LINE_W(LINE_W),
    .BUS_W (BUS_W),
    .IDX_W (IDX_W)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .load     (buf_load_s),
    .load_line(mem_data_in),
    .wr_en    (buf_wr_s),
    .wr_idx   (beat_cnt_r),
    .wr_beat  (bus_rdata),
    .rd_idx   (rd_idx_s),
    .rd_beat  (rd_beat_s),
    .fill_line(fill_line_s)
  );

  // Request FSM with beat counter and registered bus/arbiter outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r         <= ST_IDLE;
      beat_cnt_r      <= '0;
      data_from_mem   <= '0;
      mem_data_valid  <= 1'b0;
      bus_req_valid   <= 1'b0;
      bus_req_addr    <= '0;
      bus_req_write   <= 1'b0;
      bus_wdata       <= '0;
      bus_wdata_valid <= 1'b0;
    end else begin
      mem_data_valid <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (mem_req) begin
            bus_req_addr  <= {mem_address[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
            bus_req_write <= mem_wr_en;
            bus_req_valid <= 1'b1;
            state_r       <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            beat_cnt_r    <= '0;
            if (bus_req_write) begin
              bus_wdata_valid <= 1'b1;
              bus_wdata       <= rd_beat_s;
              state_r         <= ST_WDATA;
            end else begin
              state_r <= ST_RDATA;
            end
          end
        end
        ST_WDATA: begin
          if (bus_wdata_ready) begin
            if (beat_cnt_r == LAST_BEAT) begin
              bus_wdata_valid <= 1'b0;
              mem_data_valid  <= 1'b1;
              data_from_mem   <= fill_line_s;
              state_r         <= ST_DONE;
            end else begin
              beat_cnt_r <= beat_cnt_r + IDX_W'(1'b1);
              bus_wdata  <= rd_beat_s;
            end
          end
        end
        ST_RDATA: begin
          if (bus_rdata_valid) begin
            if (beat_cnt_r == LAST_BEAT) begin
              mem_data_valid <= 1'b1;
              data_from_mem  <= fill_line_s;
              state_r        <= ST_DONE;
            end else begin
              beat_cnt_r <= beat_cnt_r + IDX_W'(1'b1);
            end
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r         <= ST_IDLE;
          bus_req_valid   <= 1'b0;
          bus_wdata_valid <= 1'b0;
        end
      endcase
    end
  end

  // Snoop forwarding, independent of the request FSM.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      invalidate_cache      <= 1'b0;
      invalidate_cache_addr <= '0;
    end else begin
      invalidate_cache <= bus_snoop_valid;
      if (bus_snoop_valid) begin
        invalidate_cache_addr <= {bus_snoop_addr[ADDR_W-1:LINE_OFFSET_W], {LINE_OFFSET_W{1'b0}}};
      end else begin
        invalidate_cache_addr <= invalidate_cache_addr;
      end
    end
  end

endmodule

// File: tb/tb_mem_line_controller.sv
// Randomized bench for mem_line_controller; the bus side is driven as a transaction timeline.
module tb_mem_line_controller;

  logic         clk = 1'b0;
  logic         rst;
  logic         mem_req;
  logic [63:0]  mem_address;
  logic         mem_wr_en;
  logic [511:0] mem_data_in;
  logic [511:0] data_from_mem;
  logic         mem_data_valid;
  logic         invalidate_cache;
  logic [63:0]  invalidate_cache_addr;
  logic         bus_req_valid;
  logic         bus_req_ready;
  logic [63:0]  bus_req_addr;
  logic         bus_req_write;
  logic [63:0]  bus_wdata;
  logic         bus_wdata_valid;
  logic         bus_wdata_ready;
  logic [63:0]  bus_rdata;
  logic         bus_rdata_valid;
  logic         bus_snoop_valid;
  logic [63:0]  bus_snoop_addr;

  mem_line_controller dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_address(mem_address),
    .mem_wr_en(mem_wr_en), .mem_data_in(mem_data_in), .data_from_mem(data_from_mem),
    .mem_data_valid(mem_data_valid), .invalidate_cache(invalidate_cache),
    .invalidate_cache_addr(invalidate_cache_addr), .bus_req_valid(bus_req_valid),
    .bus_req_ready(bus_req_ready), .bus_req_addr(bus_req_addr), .bus_req_write(bus_req_write),
    .bus_wdata(bus_wdata), .bus_wdata_valid(bus_wdata_valid), .bus_wdata_ready(bus_wdata_ready),
    .bus_rdata(bus_rdata), .bus_rdata_valid(bus_rdata_valid), .bus_snoop_valid(bus_snoop_valid),
    .bus_snoop_addr(bus_snoop_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int last_valid_cyc = 0;
  int start_cyc = 0;
  bit run = 1'b0;

  // Expected outputs for the current cycle, set by the stimulus timeline.
  logic         exp_req_valid = 1'b0;
  logic [63:0]  exp_addr = 64'd0;
  logic         exp_write = 1'b0;
  logic         exp_wvalid = 1'b0;
  logic [63:0]  exp_wdata = 64'd0;
  logic         exp_dvalid = 1'b0;
  logic [511:0] exp_last = 512'd0;
  logic         exp_inv = 1'b0;
  logic [63:0]  exp_inv_addr = 64'd0;
  logic [63:0]  last_req_addr = 64'd0;
  logic [63:0]  obs_w [8];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk512(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Snoop rule: a snoop in one cycle appears as an aligned invalidate in the next.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      exp_inv      <= 1'b0;
      exp_inv_addr <= 64'd0;
    end else begin
      exp_inv <= bus_snoop_valid;
      if (bus_snoop_valid) exp_inv_addr <= {bus_snoop_addr[63:6], 6'd0};
    end
  end

  // Per-cycle comparison against the expected outputs.
  always @(negedge clk) begin
    if (run) begin
      chk1("mem_data_valid", mem_data_valid, exp_dvalid);
      chk512("data_from_mem", data_from_mem, exp_last);
      chk1("bus_req_valid", bus_req_valid, exp_req_valid);
      if (exp_req_valid) begin
        chk64("bus_req_addr", bus_req_addr, exp_addr);
        chk1("bus_req_write", bus_req_write, exp_write);
      end
      chk1("bus_wdata_valid", bus_wdata_valid, exp_wvalid);
      if (exp_wvalid) chk64("bus_wdata", bus_wdata, exp_wdata);
      chk1("invalidate_cache", invalidate_cache, exp_inv);
      if (exp_inv) chk64("invalidate_cache_addr", invalidate_cache_addr, exp_inv_addr);
      if (mem_data_valid) begin
        pulses++;
        last_valid_cyc = cyc;
      end
    end
  end

  function automatic logic [511:0] rand_line();
    logic [511:0] l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_exp(input logic rv, input logic wv, input logic [63:0] wd, input logic dv);
    exp_req_valid = rv;
    exp_wvalid    = wv;
    exp_wdata     = wd;
    exp_dvalid    = dv;
  endtask

  // Randomize every input; callers override the ones that matter in the current phase.
  task automatic noise(input bit busy);
    mem_req         = busy ? ($urandom_range(0, 3) == 0) : 1'b0;
    mem_address     = {$urandom, $urandom};
    mem_wr_en       = ($urandom_range(0, 1) == 1);
    mem_data_in     = rand_line();
    bus_req_ready   = ($urandom_range(0, 1) == 1);
    bus_wdata_ready = ($urandom_range(0, 1) == 1);
    bus_rdata_valid = ($urandom_range(0, 2) == 0);
    bus_rdata       = {$urandom, $urandom};
    bus_snoop_valid = ($urandom_range(0, 3) == 0);
    bus_snoop_addr  = {$urandom, $urandom};
  endtask

  task automatic idle_cycle();
    noise(1'b0);
    set_exp(1'b0, 1'b0, 64'd0, 1'b0);
    next_cycle();
  endtask

  task automatic req_phase(input int req_stall);
    bit r;
    for (int s = 0; ; s++) begin
      noise(1'b1);
      set_exp(1'b1, 1'b0, 64'd0, 1'b0);
      if (s == 0) last_req_addr = bus_req_addr;
      r = (s >= req_stall);
      bus_req_ready = r;
      next_cycle();
      if (r) break;
    end
  endtask

  task automatic do_reset_mid();
    #2;
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b0);
    exp_last = 512'd0;
    #1;
    chk1("rst_mem_data_valid", mem_data_valid, 1'b0);
    chk512("rst_data_from_mem", data_from_mem, 512'd0);
    chk1("rst_bus_req_valid", bus_req_valid, 1'b0);
    chk64("rst_bus_req_addr", bus_req_addr, 64'd0);
    chk1("rst_bus_req_write", bus_req_write, 1'b0);
    chk1("rst_bus_wdata_valid", bus_wdata_valid, 1'b0);
    chk64("rst_bus_wdata", bus_wdata, 64'd0);
    chk1("rst_invalidate", invalidate_cache, 1'b0);
    chk64("rst_invalidate_addr", invalidate_cache_addr, 64'd0);
    noise(1'b0);
    next_cycle();
    noise(1'b0);
    next_cycle();
    rst = 1'b1;
    idle_cycle();
  endtask

  task automatic do_read(input logic [63:0] addr, input int req_stall, input bit zero_wait,
                         input bit fixed_beats, input int snoop_beat, input int rst_beat);
    logic [511:0] line;
    logic [63:0]  beat;
    int k;
    bit snooped;
    noise(1'b0);
    mem_req = 1'b1; mem_address = addr; mem_wr_en = 1'b0;
    set_exp(1'b0, 1'b0, 64'd0, 1'b0);
    start_cyc = cyc;
    next_cycle();
    exp_addr = {addr[63:6], 6'd0};
    exp_write = 1'b0;
    req_phase(req_stall);
    line = 512'd0;
    k = 0;
    while (k < 8) begin
      noise(1'b1);
      set_exp(1'b0, 1'b0, 64'd0, 1'b0);
      snooped = 1'b0;
      if (zero_wait || $urandom_range(0, 2) != 0) begin
        beat = fixed_beats ? 64'(k) : {$urandom, $urandom};
        bus_rdata_valid = 1'b1;
        bus_rdata = beat;
        line[k*64 +: 64] = beat;
        if (k == snoop_beat) begin
          bus_snoop_valid = 1'b1;
          bus_snoop_addr  = 64'h0000_0000_2000_0013;
          snooped = 1'b1;
        end
        k++;
      end else begin
        bus_rdata_valid = 1'b0;
      end
      next_cycle();
      if (snooped) begin
        chk1("snoop_pulse", invalidate_cache, 1'b1);
        chk64("snoop_addr_lit", invalidate_cache_addr, 64'h0000_0000_2000_0000);
      end
      if (rst_beat >= 0 && k == rst_beat + 1) begin
        do_reset_mid();
        return;
      end
    end
    noise(1'b1);
    set_exp(1'b0, 1'b0, 64'd0, 1'b1);
    exp_last = line;
    next_cycle();
  endtask

  task automatic do_write(input logic [63:0] addr, input logic [511:0] line,
                          input int req_stall, input int wmode);
    int k;
    int t;
    bit r;
    noise(1'b0);
    mem_req = 1'b1; mem_address = addr; mem_wr_en = 1'b1; mem_data_in = line;
    set_exp(1'b0, 1'b0, 64'd0, 1'b0);
    next_cycle();
    exp_addr = {addr[63:6], 6'd0};
    exp_write = 1'b1;
    req_phase(req_stall);
    k = 0;
    t = 0;
    while (k < 8) begin
      noise(1'b1);
      set_exp(1'b0, 1'b1, line[k*64 +: 64], 1'b0);
      if (wmode == 2) r = 1'b1;
      else if (wmode == 1) r = (t % 2 == 0);
      else r = ($urandom_range(0, 1) == 1);
      bus_wdata_ready = r;
      if (r) begin
        obs_w[k] = bus_wdata;
        k++;
      end
      t++;
      next_cycle();
    end
    noise(1'b1);
    set_exp(1'b0, 1'b0, 64'd0, 1'b1);
    exp_last = line;
    next_cycle();
  endtask

  initial begin
    int p0;
    logic [511:0] wline;
    rst = 1'b0;
    noise(1'b0);
    set_exp(1'b0, 1'b0, 64'd0, 1'b0);
    run = 1'b1;
    next_cycle();
    next_cycle();
    rst = 1'b1;
    idle_cycle();

    // Zero-wait read with beats 0..7.
    p0 = pulses;
    do_read(64'h0000_0000_1000_0047, 0, 1'b1, 1'b1, -1, -1);
    chk64("read_req_addr_lit", last_req_addr, 64'h0000_0000_1000_0040);
    chk64("read_latency", 64'(last_valid_cyc - start_cyc), 64'd10);
    chk64("read_pulse_count", 64'(pulses - p0), 64'd1);
    for (int k = 0; k < 8; k++) chk64("read_beat_lit", data_from_mem[k*64 +: 64], 64'(k));

    // Write with alternating ready.
    for (int k = 0; k < 8; k++) wline[k*64 +: 64] = 64'hA0 + 64'(k);
    p0 = pulses;
    do_write({$urandom, $urandom}, wline, 0, 1);
    for (int k = 0; k < 8; k++) chk64("write_beat_lit", obs_w[k], 64'hA0 + 64'(k));
    chk64("write_pulse_count", 64'(pulses - p0), 64'd1);

    // Request-ready stall of 5 cycles.
    do_read({$urandom, $urandom}, 5, 1'b0, 1'b0, -1, -1);
    do_write({$urandom, $urandom}, rand_line(), 5, 0);

    // Snoop during a read, then two back-to-back snoops.
    p0 = pulses;
    do_read(64'h0000_0000_2000_0013, 0, 1'b0, 1'b0, 2, -1);
    chk64("snoop_read_pulse_count", 64'(pulses - p0), 64'd1);
    noise(1'b0);
    set_exp(1'b0, 1'b0, 64'd0, 1'b0);
    bus_snoop_valid = 1'b1;
    bus_snoop_addr  = 64'h0000_0000_4000_00FF;
    next_cycle();
    chk1("snoop_b2b_first", invalidate_cache, 1'b1);
    chk64("snoop_b2b_first_addr", invalidate_cache_addr, 64'h0000_0000_4000_00C0);
    noise(1'b0);
    bus_snoop_valid = 1'b1;
    bus_snoop_addr  = 64'h5555_5555_5555_5555;
    next_cycle();
    chk1("snoop_b2b_second", invalidate_cache, 1'b1);
    chk64("snoop_b2b_second_addr", invalidate_cache_addr, 64'h5555_5555_5555_5540);
    idle_cycle();

    // Reset after beat 3 of a read, then a fresh read.
    p0 = pulses;
    do_read({$urandom, $urandom}, 0, 1'b1, 1'b0, -1, 3);
    do_read({$urandom, $urandom}, 1, 1'b0, 1'b0, -1, -1);
    chk64("reset_read_pulse_count", 64'(pulses - p0), 64'd1);

    // Random mix of transactions.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_read({$urandom, $urandom}, $urandom_range(0, 3), 1'b0, 1'b0, -1, -1);
      else
        do_write({$urandom, $urandom}, rand_line(), $urandom_range(0, 3), 0);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    idle_cycle();

    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
